// File: rtl/clk_freq_meter.sv
// Measures period/high time of an asynchronous square wave, gated edge
// frequency, and a loss-of-signal flag, all in the CLK100MHZ domain.
module clk_freq_meter #(
  parameter int CNT_W          = 32,
  parameter int GATE_CYCLES    = 100_000_000,
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             period_valid,
  output logic [CNT_W-1:0] freq_hz,
  output logic             freq_valid,
  output logic             no_signal
);

  localparam logic [0:0] WAIT_FIRST = 1'b0;
  localparam logic [0:0] MEASURE    = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GATE_END = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);

  logic             sync0, sync1, hist;
  logic             rise, fall;
  logic [0:0]       state;
  logic [CNT_W-1:0] per_cnt, hi_cnt, hi_hold;
  logic             fell;
  logic [CNT_W-1:0] gate_cnt, edge_cnt;

  assign rise = sync1 & ~hist;
  assign fall = ~sync1 & hist;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync0         <= 1'b0;
      sync1         <= 1'b0;
      hist          <= 1'b0;
      state         <= WAIT_FIRST;
      per_cnt       <= '0;
      hi_cnt        <= '0;
      hi_hold       <= '0;
      fell          <= 1'b0;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      period_cycles <= '0;
      high_cycles   <= '0;
      period_valid  <= 1'b0;
      freq_hz       <= '0;
      freq_valid    <= 1'b0;
      no_signal     <= 1'b1;
    end else begin
      sync0        <= sig_in;
      sync1        <= sync0;
      hist         <= sync1;
      period_valid <= 1'b0;
      freq_valid   <= 1'b0;

      if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_ONE;
      if (sync1 && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_ONE;

      if (fall) begin
        hi_hold <= hi_cnt;
        fell    <= 1'b1;
      end

      // A rise overrides the increments above; fell gates whether hi_hold
      // belongs to the period that is closing.
      if (rise) begin
        no_signal <= 1'b0;
        if (state == MEASURE) begin
          period_cycles <= per_cnt;
          high_cycles   <= fell ? hi_hold : per_cnt;
          period_valid  <= 1'b1;
        end
        state   <= MEASURE;
        per_cnt <= CNT_ONE;
        hi_cnt  <= CNT_ONE;
        fell    <= 1'b0;
      end else if (state == MEASURE && per_cnt == TIMEOUT) begin
        no_signal <= 1'b1;
        state     <= WAIT_FIRST;
      end

      // A rise on the last gate cycle is folded into the closing result.
      if (gate_cnt == GATE_END) begin
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        freq_valid <= 1'b1;
        freq_hz    <= (edge_cnt == CNT_MAX) ? edge_cnt : edge_cnt + CNT_W'(rise);
      end else begin
        gate_cnt <= gate_cnt + CNT_ONE;
        if (rise && edge_cnt != CNT_MAX) edge_cnt <= edge_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Randomized self-checking bench for clk_freq_meter using a timestamp-based
// reference model (edge times, rise queue) rather than counters.
module tb_clk_freq_meter;
  localparam int GATE = 1000;
  localparam int TMO  = 500;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig_in = 1'b0;
  logic [31:0] period_cycles, high_cycles, freq_hz;
  logic        period_valid, freq_valid, no_signal;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: absolute edge numbers of events.
  int          edge_n = 0;
  int          rel_edge = 0;
  bit          s1, s2, s3;
  bit          armed, fell, m_rise;
  int          last_rise, last_fall;
  int          q[$];
  logic [31:0] exp_per, exp_hi, exp_freq;
  bit          exp_pv, exp_fv, exp_ns;

  clk_freq_meter #(
    .CNT_W(32),
    .GATE_CYCLES(GATE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK100MHZ(clk),
    .reset(reset),
    .sig_in(sig_in),
    .period_cycles(period_cycles),
    .high_cycles(high_cycles),
    .period_valid(period_valid),
    .freq_hz(freq_hz),
    .freq_valid(freq_valid),
    .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  // Drives one cycle of stimulus and advances the model to that edge.
  task automatic tick(input bit v, input bit r);
    bit fl;
    @(negedge clk);
    sig_in = v;
    reset  = r;
    @(posedge clk);
    edge_n++;
    m_rise = 1'b0;
    if (r) begin
      s1 = 0; s2 = 0; s3 = 0;
      armed = 0; fell = 0;
      exp_per = '0; exp_hi = '0; exp_freq = '0;
      exp_pv = 0; exp_fv = 0; exp_ns = 1;
      rel_edge = edge_n;
      q.delete();
    end else begin
      m_rise = s2 & ~s3;
      fl     = ~s2 & s3;
      exp_pv = 0;
      exp_fv = 0;
      if (fl) begin
        last_fall = edge_n;
        fell = 1;
      end
      if (m_rise) begin
        if (armed) begin
          exp_pv  = 1;
          exp_per = 32'(edge_n - last_rise);
          exp_hi  = fell ? 32'(last_fall - last_rise) : exp_per;
        end
        armed = 1;
        fell = 0;
        last_rise = edge_n;
        exp_ns = 0;
        q.push_back(edge_n);
      end else if (armed && edge_n - last_rise == TMO) begin
        exp_ns = 1;
        armed = 0;
      end
      if ((edge_n - rel_edge) % GATE == 0) begin
        while (q.size() > 0 && q[0] <= edge_n - GATE) void'(q.pop_front());
        exp_freq = 32'(q.size());
        exp_fv = 1;
      end
      s3 = s2; s2 = s1; s1 = v;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pv got %0b want 0", period_valid); end
    n_cmp++; if (freq_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fv got %0b want 0", freq_valid); end
    n_cmp++; if (no_signal !== 1'b1) begin n_bad++; $display("FAIL rst_ns got %0b want 1", no_signal); end
    n_cmp++; if (period_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_per got %0d want 0", period_cycles); end
    n_cmp++; if (high_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_hi got %0d want 0", high_cycles); end
    n_cmp++; if (freq_hz !== 32'd0) begin n_bad++; $display("FAIL rst_freq got %0d want 0", freq_hz); end
  endtask

  task automatic test_period4();
    int pulses = 0;
    tick(1'b0, 1'b1);
    for (int k = 0; k < 80; k++) begin
      tick((k % 4) < 2, 1'b0);
      n_cmp++; if (period_valid !== exp_pv) begin n_bad++; $display("FAIL p4_pv @%0d got %0b want %0b", edge_n, period_valid, exp_pv); end
      n_cmp++; if (period_cycles !== exp_per) begin n_bad++; $display("FAIL p4_per @%0d got %0d want %0d", edge_n, period_cycles, exp_per); end
      n_cmp++; if (high_cycles !== exp_hi) begin n_bad++; $display("FAIL p4_hi @%0d got %0d want %0d", edge_n, high_cycles, exp_hi); end
      n_cmp++; if (no_signal !== exp_ns) begin n_bad++; $display("FAIL p4_ns @%0d got %0b want %0b", edge_n, no_signal, exp_ns); end
      if (period_valid === 1'b1) begin
        pulses++;
        n_cmp++; if (period_cycles !== 32'd4 || high_cycles !== 32'd2) begin n_bad++; $display("FAIL p4_value got %0d/%0d want 4/2", period_cycles, high_cycles); end
      end
    end
    n_cmp++; if (pulses != 19) begin n_bad++; $display("FAIL p4_pulses got %0d want 19", pulses); end
  endtask

  task automatic test_toggle();
    int gates = 0;
    tick(1'b0, 1'b1);
    for (int k = 0; k < 3100; k++) begin
      tick((k % 2) == 0, 1'b0);
      n_cmp++; if (period_valid !== exp_pv) begin n_bad++; $display("FAIL tg_pv @%0d got %0b want %0b", edge_n, period_valid, exp_pv); end
      n_cmp++; if (period_cycles !== exp_per || high_cycles !== exp_hi) begin n_bad++; $display("FAIL tg_per @%0d got %0d/%0d want %0d/%0d", edge_n, period_cycles, high_cycles, exp_per, exp_hi); end
      n_cmp++; if (freq_valid !== exp_fv) begin n_bad++; $display("FAIL tg_fv @%0d got %0b want %0b", edge_n, freq_valid, exp_fv); end
      n_cmp++; if (freq_hz !== exp_freq) begin n_bad++; $display("FAIL tg_freq @%0d got %0d want %0d", edge_n, freq_hz, exp_freq); end
      if (freq_valid === 1'b1) begin
        gates++;
        if (gates > 1) begin
          n_cmp++; if (freq_hz !== 32'd500) begin n_bad++; $display("FAIL tg_500 got %0d want 500", freq_hz); end
        end
      end
    end
    n_cmp++; if (gates != 3) begin n_bad++; $display("FAIL tg_gates got %0d want 3", gates); end
  endtask

  task automatic test_gate_boundary();
    int gates, off, hi;
    for (int seg = 0; seg < 2; seg++) begin
      gates = 0;
      off = (seg == 0) ? int'($urandom_range(0, 199)) : 198;
      hi  = (seg == 0) ? int'($urandom_range(1, 199)) : 50;
      tick(1'b0, 1'b1);
      for (int e = 1; e <= 2010; e++) begin
        tick(((e + 200 - off) % 200) < hi, 1'b0);
        n_cmp++; if (freq_valid !== exp_fv) begin n_bad++; $display("FAIL gb_fv @%0d got %0b want %0b", edge_n, freq_valid, exp_fv); end
        n_cmp++; if (freq_hz !== exp_freq) begin n_bad++; $display("FAIL gb_freq @%0d got %0d want %0d", edge_n, freq_hz, exp_freq); end
        n_cmp++; if (period_cycles !== exp_per || high_cycles !== exp_hi) begin n_bad++; $display("FAIL gb_per @%0d got %0d/%0d want %0d/%0d", edge_n, period_cycles, high_cycles, exp_per, exp_hi); end
        if (freq_valid === 1'b1) begin
          gates++;
          if (gates > 1) begin
            n_cmp++; if (freq_hz !== 32'd5) begin n_bad++; $display("FAIL gb_5 got %0d want 5", freq_hz); end
          end else if (seg == 1) begin
            n_cmp++; if (freq_hz !== 32'd6) begin n_bad++; $display("FAIL gb_first got %0d want 6", freq_hz); end
          end
        end
      end
      n_cmp++; if (gates != 2) begin n_bad++; $display("FAIL gb_gates got %0d want 2", gates); end
    end
  endtask

  task automatic test_timeout();
    int p, h, rises_seen;
    bit prev_ns;
    p = int'($urandom_range(4, 20));
    h = int'($urandom_range(1, p - 1));
    rises_seen = 0;
    tick(1'b0, 1'b1);
    prev_ns = 1'b1;
    for (int k = 0; k < 100 + 700 + 80; k++) begin
      tick((k < 100 || k >= 800) ? ((k % p) < h) : 1'b0, 1'b0);
      n_cmp++; if (no_signal !== exp_ns) begin n_bad++; $display("FAIL to_ns @%0d got %0b want %0b", edge_n, no_signal, exp_ns); end
      n_cmp++; if (period_valid !== exp_pv) begin n_bad++; $display("FAIL to_pv @%0d got %0b want %0b", edge_n, period_valid, exp_pv); end
      n_cmp++; if (period_cycles !== exp_per || high_cycles !== exp_hi) begin n_bad++; $display("FAIL to_per @%0d got %0d/%0d want %0d/%0d", edge_n, period_cycles, high_cycles, exp_per, exp_hi); end
      if (prev_ns === 1'b0 && no_signal === 1'b1) begin
        n_cmp++; if (edge_n - last_rise != TMO) begin n_bad++; $display("FAIL to_delay got %0d want %0d", edge_n - last_rise, TMO); end
      end
      if (k >= 800 && m_rise) begin
        rises_seen++;
        if (rises_seen == 2) begin
          n_cmp++; if (period_cycles !== 32'(p) || high_cycles !== 32'(h)) begin n_bad++; $display("FAIL to_recover got %0d/%0d want %0d/%0d", period_cycles, high_cycles, p, h); end
        end
      end
      prev_ns = no_signal;
    end
  endtask

  task automatic test_reset_mid();
    int p, h, run, first_fv;
    p = int'($urandom_range(5, 60));
    h = int'($urandom_range(1, p - 1));
    run = int'($urandom_range(300, 800));
    tick(1'b0, 1'b1);
    for (int k = 0; k < run; k++) tick((k % p) < h, 1'b0);
    tick(1'b1, 1'b1);
    n_cmp++; if (period_valid !== 1'b0 || freq_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid got %0b/%0b want 0/0", period_valid, freq_valid); end
    n_cmp++; if (no_signal !== 1'b1) begin n_bad++; $display("FAIL rm_ns got %0b want 1", no_signal); end
    n_cmp++; if (period_cycles !== 32'd0 || high_cycles !== 32'd0 || freq_hz !== 32'd0) begin n_bad++; $display("FAIL rm_vals got %0d/%0d/%0d want 0/0/0", period_cycles, high_cycles, freq_hz); end
    first_fv = 0;
    for (int e = 1; e <= 1100; e++) begin
      tick(((e + 7) % p) < h, 1'b0);
      n_cmp++; if (period_valid !== exp_pv) begin n_bad++; $display("FAIL rm_pv @%0d got %0b want %0b", edge_n, period_valid, exp_pv); end
      n_cmp++; if (freq_valid !== exp_fv || freq_hz !== exp_freq) begin n_bad++; $display("FAIL rm_freq @%0d got %0b/%0d want %0b/%0d", edge_n, freq_valid, freq_hz, exp_fv, exp_freq); end
      n_cmp++; if (period_cycles !== exp_per || high_cycles !== exp_hi) begin n_bad++; $display("FAIL rm_per @%0d got %0d/%0d want %0d/%0d", edge_n, period_cycles, high_cycles, exp_per, exp_hi); end
      if (freq_valid === 1'b1 && first_fv == 0) first_fv = e;
    end
    n_cmp++; if (first_fv != GATE) begin n_bad++; $display("FAIL rm_first_fv got %0d want %0d", first_fv, GATE); end
  endtask

  task automatic test_held_high();
    int clr_at, set_at;
    bit prev_ns;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    clr_at = -1;
    set_at = -1;
    prev_ns = 1'b1;
    for (int e = 1; e <= 600; e++) begin
      tick(1'b1, 1'b0);
      n_cmp++; if (no_signal !== exp_ns) begin n_bad++; $display("FAIL hh_ns @%0d got %0b want %0b", edge_n, no_signal, exp_ns); end
      n_cmp++; if (period_valid !== 1'b0) begin n_bad++; $display("FAIL hh_pv @%0d got %0b want 0", edge_n, period_valid); end
      if (prev_ns === 1'b1 && no_signal === 1'b0 && clr_at < 0) clr_at = e;
      if (prev_ns === 1'b0 && no_signal === 1'b1 && set_at < 0) set_at = e;
      prev_ns = no_signal;
    end
    n_cmp++; if (clr_at != 3) begin n_bad++; $display("FAIL hh_clear got %0d want 3", clr_at); end
    n_cmp++; if (set_at != 3 + TMO) begin n_bad++; $display("FAIL hh_reassert got %0d want %0d", set_at, 3 + TMO); end
  endtask

  initial begin
    test_reset();
    test_period4();
    test_toggle();
    test_gate_boundary();
    test_timeout();
    test_reset_mid();
    test_held_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_freq_meter.md
CLK_FREQ_METER -- requirements
Module: clk_freq_meter

Interface
REQ-001 Parameter CNT_W, 32, width of every counter and measurement output.
REQ-002 Parameter GATE_CYCLES, 100_000_000, frequency gate length in CLK100MHZ cycles (1 s gives freq_hz in Hz).
REQ-003 Parameter TIMEOUT_CYCLES, 200_000_000, cycles without a rising edge before no_signal asserts; SHALL be < 2^CNT_W-1.
REQ-004 CLK100MHZ  in  1  sole clock, 100 MHz; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sig_in  in  1  asynchronous square wave under test (e.g. PMOD JA pin).
REQ-007 period_cycles  out  CNT_W  last rising-to-rising interval in CLK100MHZ cycles.
REQ-008 high_cycles  out  CNT_W  high time of the same period, in cycles.
REQ-009 period_valid  out  1  one-cycle pulse when period_cycles/high_cycles update.
REQ-010 freq_hz  out  CNT_W  rising edges counted in the last completed gate.
REQ-011 freq_valid  out  1  one-cycle pulse when freq_hz updates.
REQ-012 no_signal  out  1  level; high while no rising edge within TIMEOUT_CYCLES.

Function
REQ-013 sig_in SHALL pass a 2-flop synchronizer plus one history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-014 Latency from sig_in change to rise/fall detection SHALL be 3 cycles; outputs update 1 cycle after detection.
REQ-015 Period FSM states: WAIT_FIRST, MEASURE; reset enters WAIT_FIRST.
REQ-016 WAIT_FIRST + rise -> MEASURE, per_cnt<=1, hi_cnt<=1, no period_valid.
REQ-017 MEASURE + rise -> period_cycles<=per_cnt, high_cycles<=hi_hold, period_valid<=1, per_cnt<=1, hi_cnt<=1.
REQ-018 Otherwise per_cnt increments each cycle, saturating at 2^CNT_W-1; hi_cnt increments while sync high, saturating.
REQ-019 On fall, hi_hold<=hi_cnt; a period with no fall since its rise reports high_cycles = per_cnt.
REQ-020 Result: square wave of period P cycles, high H cycles -> period_cycles=P, high_cycles=H; minimum P=2, H=1.
REQ-021 MEASURE and per_cnt==TIMEOUT_CYCLES with no rise that cycle -> no_signal<=1, state<=WAIT_FIRST.
REQ-022 Any rise SHALL clear no_signal on the next cycle.
REQ-023 gate_cnt SHALL run 0..GATE_CYCLES-1 free from reset and wrap; edge_cnt increments on each rise, saturating.
REQ-024 When gate_cnt==GATE_CYCLES-1: freq_hz<=edge_cnt+rise, freq_valid<=1, edge_cnt<=0; a rise on that cycle counts in the ending gate.
REQ-025 period_valid and freq_valid SHALL be 0 on all cycles not named in REQ-017/REQ-024 and may coincide.

Reset
REQ-026 reset SHALL dominate all logic on the cycle sampled, including mid-period and mid-gate.
REQ-027 Reset values: period_cycles=0, high_cycles=0, freq_hz=0, period_valid=0, freq_valid=0, no_signal=1; all counters, synchronizer and history flops=0.
REQ-028 Synchronizer reset to 0, so sig_in held high through reset release yields one rise 3 cycles later.

Verification (bench: GATE_CYCLES=1000, TIMEOUT_CYCLES=500)
REQ-029 sig_in period 4, high 2 after reset -> first rise gives no pulse, then period_valid every 4 cycles with period_cycles=4, high_cycles=2; no_signal low.
REQ-030 sig_in period 2 (toggle every cycle) -> period_cycles=2, high_cycles=1; freq_hz=500 each gate, freq_valid every 1000 cycles.
REQ-031 sig_in period 200, high 50, rises off gate boundary -> freq_hz=5 per gate; with a rise on gate_cnt==999 -> that edge counts in the ending gate, and the next gate excludes it.
REQ-032 Active sig_in, then held low -> no_signal=1 exactly 500 cycles after the last rise detection, with no period_valid; the next rise clears no_signal without period_valid; the following rise reports a correct period.
REQ-033 reset asserted mid-period and mid-gate -> next cycle all outputs equal REQ-027 values; the first rise after release gives no period_valid; the first freq_valid arrives 1000 cycles after release.
REQ-034 sig_in held high across reset release -> one rise detected at release+3, no_signal clears, and no_signal reasserts 500 cycles later.
